mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 89 ++++++++
 tb/tb_mem_port_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, the data port and the shared single-port memory.
// slave = arbiter side, master = requesters plus memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR = 16,
  parameter int WORD = 32
);
  // Handshake: a request is accepted in the cycle where req and gnt are both 1;
  // gnt is combinational from req, and the read response arrives exactly one
  // cycle later as an rvalid pulse with data that is 0 whenever rvalid is 0.
  logic            if_req;
  logic [ADDR-1:0] if_addr;
  logic            if_flush;
  logic            if_gnt;
  logic            if_stall;
  logic            if_rvalid;
  logic [WORD-1:0] if_rdata;
  logic            d_req;
  logic            d_we;
  logic [ADDR-1:0] d_addr;
  logic [WORD-1:0] d_wdata;
  logic            d_gnt;
  logic            d_rvalid;
  logic [WORD-1:0] d_rdata;
  logic            mem_en;
  logic            mem_we;
  logic [ADDR-1:0] mem_addr;
  logic [WORD-1:0] mem_wdata;
  logic [WORD-1:0] mem_rdata;
  logic [15:0]     conf_cnt;

  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_stall, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, conf_cnt
  );

  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_stall, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, conf_cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one single-port memory with 1-cycle reads.
// Define MEM_ARB_RR_EN for round-robin conflict resolution; default is data-first priority.
module mem_port_arbiter #(
  parameter int ADDR = 16,
  parameter int WORD = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus,
  output logic [1:0]           owner_state
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  owner_t          owner_q, owner_d;
  logic            conflict;
  logic            data_wins;
  logic            grant_if, grant_d;
  logic [ADDR-1:0] addr_mux;
  logic [WORD-1:0] rdata_if, rdata_d;
  logic            rvalid_if, rvalid_d;
  logic [15:0]     conf_q;

  assign conflict = reset & bus.if_req & bus.d_req;

`ifdef MEM_ARB_RR_EN
  // 1 means data wins the next conflict; flips only when a conflict is resolved.
  logic rr_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        rr_data_q <= 1'b1;
    else if (conflict) rr_data_q <= ~rr_data_q;
  end

  assign data_wins = rr_data_q;
`else
  assign data_wins = 1'b1;
`endif

  assign grant_d  = reset & bus.d_req & (~bus.if_req | data_wins);
  assign grant_if = reset & bus.if_req & ~grant_d;

  always_comb begin
    addr_mux = '0;
    if (grant_d)       addr_mux = bus.d_addr;
    else if (grant_if) addr_mux = bus.if_addr;
  end

  // A fetch granted alongside a flush is cancelled by recording no owner.
  always_comb begin
    owner_d = OWN_NONE;
    if (grant_if && !bus.if_flush)  owner_d = OWN_IF;
    else if (grant_d && !bus.d_we)  owner_d = OWN_D;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) owner_q <= OWN_NONE;
    else        owner_q <= owner_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      conf_q <= 16'd0;
    else if (conflict && conf_q != 16'hFFFF) conf_q <= conf_q + 16'd1;
  end

  assign rvalid_if = reset & (owner_q == OWN_IF) & ~bus.if_flush;
  assign rvalid_d  = reset & (owner_q == OWN_D);
  assign rdata_if  = rvalid_if ? bus.mem_rdata : '0;
  assign rdata_d   = rvalid_d  ? bus.mem_rdata : '0;

  assign bus.if_gnt    = grant_if;
  assign bus.if_stall  = bus.if_req & ~grant_if;
  assign bus.if_rvalid = rvalid_if;
  assign bus.if_rdata  = rdata_if;
  assign bus.d_gnt     = grant_d;
  assign bus.d_rvalid  = rvalid_d;
  assign bus.d_rdata   = rdata_d;
  assign bus.mem_en    = grant_if | grant_d;
  assign bus.mem_we    = grant_d & bus.d_we;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = bus.d_wdata;
  assign bus.conf_cnt  = conf_q;
  assign owner_state   = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter against a cycle-level reference model.
module tb_mem_port_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] owner_state;
  int         total;
  int         bad;

  mem_port_arbiter_if #(.ADDR(16), .WORD(32)) bus ();

  mem_port_arbiter #(.ADDR(16), .WORD(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .owner_state (owner_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5a, 8'hc3};
  endfunction

  // Memory with one-cycle read latency; unwritten words read as pat(addr).
  logic [31:0] tb_mem [256];
  bit          tb_wr  [256];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        tb_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        tb_wr[bus.mem_addr[7:0]]  <= 1'b1;
      end else begin
        bus.mem_rdata <= tb_wr[bus.mem_addr[7:0]] ? tb_mem[bus.mem_addr[7:0]]
                                                   : pat(bus.mem_addr[7:0]);
      end
    end
  end

  // Reference model state: shadow memory, the read expected next cycle, conflict history.
  logic [31:0] ref_mem [256];
  int          pend_who;   // 0 nobody, 1 fetch, 2 data
  logic [31:0] pend_data;
  int          ref_conf;
  int          last_winner; // 0 no conflict since reset, 1 fetch, 2 data

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend_who    = 0;
    pend_data   = '0;
    ref_conf    = 0;
    last_winner = 0;
  endtask

  task automatic step(input logic ir, input logic [15:0] ia, input logic ifl,
                      input logic dr, input logic dwe, input logic [15:0] da,
                      input logic [31:0] dwd, input bit chk);
    bit          data_first, e_dg, e_ig, e_irv, e_drv;
    logic [15:0] e_addr;
    @(posedge clk);
    #1;
    bus.if_req   = ir;
    bus.if_addr  = ia;
    bus.if_flush = ifl;
    bus.d_req    = dr;
    bus.d_we     = dwe;
    bus.d_addr   = da;
    bus.d_wdata  = dwd;
    #4;
`ifdef MEM_ARB_RR_EN
    data_first = (last_winner != 2);
`else
    data_first = 1'b1;
`endif
    e_dg   = dr && (!ir || data_first);
    e_ig   = ir && !e_dg;
    e_addr = e_dg ? da : (e_ig ? ia : 16'h0);
    e_irv  = (pend_who == 1) && !ifl;
    e_drv  = (pend_who == 2);
    if (chk) begin
      check("if_gnt",    {31'b0, bus.if_gnt},    {31'b0, e_ig});
      check("d_gnt",     {31'b0, bus.d_gnt},     {31'b0, e_dg});
      check("if_stall",  {31'b0, bus.if_stall},  {31'b0, ir && !e_ig});
      check("mem_en",    {31'b0, bus.mem_en},    {31'b0, e_ig || e_dg});
      check("mem_we",    {31'b0, bus.mem_we},    {31'b0, e_dg && dwe});
      check("mem_addr",  {16'b0, bus.mem_addr},  {16'b0, e_addr});
      check("mem_wdata", bus.mem_wdata,          dwd);
      check("if_rvalid", {31'b0, bus.if_rvalid}, {31'b0, e_irv});
      check("if_rdata",  bus.if_rdata,           e_irv ? pend_data : 32'h0);
      check("d_rvalid",  {31'b0, bus.d_rvalid},  {31'b0, e_drv});
      check("d_rdata",   bus.d_rdata,            e_drv ? pend_data : 32'h0);
      check("conf_cnt",  {16'b0, bus.conf_cnt},  ref_conf);
    end
    if (ir && dr) begin
      if (ref_conf < 65535) ref_conf++;
      last_winner = e_dg ? 2 : 1;
    end
    pend_who = 0;
    if (e_ig && !ifl) begin
      pend_who  = 1;
      pend_data = ref_mem[ia[7:0]];
    end else if (e_dg && !dwe) begin
      pend_who  = 2;
      pend_data = ref_mem[da[7:0]];
    end else if (e_dg && dwe) begin
      ref_mem[da[7:0]] = dwd;
    end
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
  endtask

  initial begin
    bit g_d [4];
    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i[7:0]);
    model_reset();
    reset        = 1'b0;
    bus.if_req   = 1'b1;
    bus.if_addr  = 16'h0;
    bus.if_flush = 1'b0;
    bus.d_req    = 1'b1;
    bus.d_we     = 1'b0;
    bus.d_addr   = 16'h0;
    bus.d_wdata  = 32'h0;

    // Requests held high during reset must not be granted.
    repeat (2) @(negedge clk);
    check("rst_if_gnt",    {31'b0, bus.if_gnt},    32'h0);
    check("rst_d_gnt",     {31'b0, bus.d_gnt},     32'h0);
    check("rst_mem_en",    {31'b0, bus.mem_en},    32'h0);
    check("rst_mem_we",    {31'b0, bus.mem_we},    32'h0);
    check("rst_if_rvalid", {31'b0, bus.if_rvalid}, 32'h0);
    check("rst_d_rvalid",  {31'b0, bus.d_rvalid},  32'h0);
    check("rst_conf_cnt",  {16'b0, bus.conf_cnt},  32'h0);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;

    // Fetch-only stream, addresses 0..3 back to back.
    for (int a = 0; a < 4; a++) begin
      step(1'b1, a[15:0], 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
      check("fetch_gnt", {31'b0, bus.if_gnt}, 32'h1);
      if (a > 0) check("fetch_beat", bus.if_rdata, pat(8'(a - 1)));
    end
    idle();
    check("fetch_last", bus.if_rdata, pat(8'd3));

`ifdef MEM_ARB_RR_EN
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 16'h40, 1'b0, 1'b1, 1'b0, 16'h41, 32'h0, 1'b1);
      g_d[c] = bus.d_gnt;
    end
    check("rr_order", {28'b0, g_d[0], g_d[1], g_d[2], g_d[3]}, 32'b1010);
    idle();
    check("rr_conf", {16'b0, bus.conf_cnt}, 32'd4);
`else
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 16'h40, 1'b0, 1'b1, 1'b0, 16'h41, 32'h0, 1'b1);
      g_d[c] = bus.d_gnt;
      check("conf_stall", {31'b0, bus.if_stall}, 32'h1);
    end
    check("conf_dgnt", {29'b0, g_d[0], g_d[1], g_d[2]}, 32'b111);
    idle();
    check("conf_cnt3", {16'b0, bus.conf_cnt}, 32'd3);
`endif

    // Flush in the fetch response cycle while a data load is granted and returned.
    step(1'b1, 16'h10, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
    step(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h11, 32'h0, 1'b1);
    check("flush_rvalid", {31'b0, bus.if_rvalid}, 32'h0);
    check("flush_dgnt",   {31'b0, bus.d_gnt},     32'h1);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
    check("flush_d_rvalid", {31'b0, bus.d_rvalid}, 32'h1);
    check("flush_d_rdata",  bus.d_rdata,           pat(8'h11));

    // Store then load back.
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'h20, 32'hDEADBEEF, 1'b1);
    check("store_we", {31'b0, bus.mem_we}, 32'h1);
    step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h20, 32'h0, 1'b1);
    check("store_no_rvalid", {31'b0, bus.d_rvalid}, 32'h0);
    idle();
    check("load_back", bus.d_rdata, 32'hDEADBEEF);

    // Randomised traffic, addresses confined to the modelled 256 words.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)),
           ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)), $urandom, 1'b1);
    end

    // Saturation of the conflict counter.
    for (int n = 0; n < 70000; n++)
      step(1'b1, 16'h2, 1'b0, 1'b1, 1'b0, 16'h3, 32'h0, 1'b0);
    idle();
    check("conf_sat", {16'b0, bus.conf_cnt}, 32'h0000FFFF);

    // Reset while a fetch read is pending.
    step(1'b1, 16'h5, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
    @(posedge clk);
    #1 reset = 1'b0;
    #4;
    check("midrst_if_gnt",    {31'b0, bus.if_gnt},    32'h0);
    check("midrst_if_rvalid", {31'b0, bus.if_rvalid}, 32'h0);
    check("midrst_conf",      {16'b0, bus.conf_cnt},  32'h0);
    bus.if_req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    idle();
    check("post_rst_if_rvalid", {31'b0, bus.if_rvalid}, 32'h0);
    check("post_rst_d_rvalid",  {31'b0, bus.d_rvalid},  32'h0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
